// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle LEGv8 control FSM (fetch/decode/exec/mem/wb/branch/halt)
module multicycle_control #(
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 reg2_loc,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 instr_done,
  output logic                 halted,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_ORR    = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;

  state_t state_q, state_d;

  logic [10:0] opc11;
  logic        is_add, is_sub, is_and, is_orr, is_rtype;
  logic        is_ldur, is_stur, is_cbz, is_b;
  logic [3:0]  rtype_alu_op;
  logic        unused_instr_bits;

  // Only the opcode field steers control; operand fields go straight to the datapath.
  assign opc11             = instruction[31:21];
  assign unused_instr_bits = ^instruction[20:0];
  assign state             = state_q;

  // Opcode classification of the latched instruction register
  always_comb begin
    is_add       = (opc11 == 11'h458);
    is_sub       = (opc11 == 11'h658);
    is_and       = (opc11 == 11'h450);
    is_orr       = (opc11 == 11'h550);
    is_ldur      = (opc11 == 11'h7C2);
    is_stur      = (opc11 == 11'h7C0);
    is_cbz       = (instruction[31:24] == 8'hB4);
    is_b         = (instruction[31:26] == 6'h05);
    is_rtype     = is_add | is_sub | is_and | is_orr;
    rtype_alu_op = ALU_ADD;
    if (is_sub) rtype_alu_op = ALU_SUB;
    if (is_and) rtype_alu_op = ALU_AND;
    if (is_orr) rtype_alu_op = ALU_ORR;
  end

  // Next-state sequencing; memory handshakes stall FETCH and MEM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_rtype || is_ldur || is_stur) state_d = S_EXEC;
        else if (is_cbz || is_b)            state_d = S_BRANCH;
        else                                state_d = S_HALT;
      end
      S_EXEC:   state_d = is_rtype ? S_WB : S_MEM;
      S_MEM:    if (dmem_ready) state_d = is_ldur ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Control outputs decoded from state; forced low while reset is held
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg2_loc   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        if (is_rtype) begin
          alu_op = rtype_alu_op;
        end else begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        alu_src  = 1'b1;
        alu_op   = ALU_ADD;
        if (is_stur) begin
          dmem_write = 1'b1;
          reg2_loc   = 1'b1;
          pc_write   = dmem_ready;
          instr_done = dmem_ready;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ldur;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (is_rtype) alu_op = rtype_alu_op;
      end
      S_BRANCH: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (is_b) begin
          pc_src = 1'b1;
        end else begin
          reg2_loc = 1'b1;
          alu_op   = ALU_PASS_B;
          pc_src   = zero;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (!reset_n) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      dmem_req   = 1'b0;
      dmem_write = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg2_loc   = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 4'b0000;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

  // State register, the only storage in the block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control
module tb_multicycle_control;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, ir_write, dmem_req, dmem_write, reg_write, mem_to_reg;
  logic        reg2_loc, alu_src, pc_write, pc_src, instr_done, halted;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] r_ins [3];
  logic [3:0]  r_op  [3];

  multicycle_control #(.INSTR_LEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
    .dmem_write(dmem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg2_loc(reg2_loc), .alu_src(alu_src), .alu_op(alu_op),
    .pc_write(pc_write), .pc_src(pc_src), .instr_done(instr_done),
    .halted(halted), .state(state)
  );

  assign ctrl = {imem_req, ir_write, dmem_req, dmem_write, reg_write, mem_to_reg,
                 reg2_loc, alu_src, alu_op, pc_write, pc_src, instr_done, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cv(input logic ir, input logic iw, input logic dr,
                                     input logic dw, input logic rw, input logic m2r,
                                     input logic r2, input logic as, input logic [3:0] op,
                                     input logic pw, input logic ps, input logic dn,
                                     input logic h);
    return {ir, iw, dr, dw, rw, m2r, r2, as, op, pw, ps, dn, h};
  endfunction

  task automatic check(input string tag, input logic [2:0] es, input logic [15:0] ec);
    n_tests++;
    assert (state === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
    end
    n_tests++;
    assert (ctrl === ec) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, ctrl, ec);
    end
  endtask

  task automatic run_cycle(input string tag, input logic [2:0] es, input logic [15:0] ec);
    @(negedge clk);
    check(tag, es, ec);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h8B09026A;
  localparam logic [31:0] I_LDUR = 32'hF84402C9;
  localparam logic [31:0] I_STUR = 32'hF80602CB;
  localparam logic [31:0] I_CBZ  = 32'hB4FFFF6B;
  localparam logic [31:0] I_B    = 32'h17FFFFC9;

  initial begin
    logic [15:0] f_rdy, f_wait, mem_ld, br_cbz0, br_cbz1, br_b, hlt;
    f_rdy   = cv(1,1,0,0,0,0,0,0,4'b0000,0,0,0,0);
    f_wait  = cv(1,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
    mem_ld  = cv(0,0,1,0,0,0,0,1,4'b0010,0,0,0,0);
    br_cbz1 = cv(0,0,0,0,0,0,1,0,4'b0111,1,1,1,0);
    br_cbz0 = cv(0,0,0,0,0,0,1,0,4'b0111,1,0,1,0);
    br_b    = cv(0,0,0,0,0,0,0,0,4'b0000,1,1,1,0);
    hlt     = cv(0,0,0,0,0,0,0,0,4'b0000,0,0,0,1);
    r_ins[0] = 32'hCB020020; r_op[0] = 4'b0110;
    r_ins[1] = 32'h8A020020; r_op[1] = 4'b0000;
    r_ins[2] = 32'hAA020020; r_op[2] = 4'b0001;

    reset_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
    instruction = 32'h0;
    #12;
    check("reset_hold", 3'd0, 16'h0);
    @(posedge clk); #1;
    check("reset_edge", 3'd0, 16'h0);
    reset_n = 1'b1;

    // ADD, spurious dmem_ready high throughout
    run_cycle("add_fetch", 3'd0, f_rdy);
    instruction = I_ADD;
    run_cycle("add_decode", 3'd1, 16'h0);
    run_cycle("add_exec", 3'd2, cv(0,0,0,0,0,0,0,0,4'b0010,0,0,0,0));
    run_cycle("add_wb", 3'd4, cv(0,0,0,0,1,0,0,0,4'b0010,1,0,1,0));

    // SUB, AND, ORR
    for (int k = 0; k < 3; k++) begin
      run_cycle("r_fetch", 3'd0, f_rdy);
      instruction = r_ins[k];
      run_cycle("r_decode", 3'd1, 16'h0);
      run_cycle("r_exec", 3'd2, cv(0,0,0,0,0,0,0,0,r_op[k],0,0,0,0));
      run_cycle("r_wb", 3'd4, cv(0,0,0,0,1,0,0,0,r_op[k],1,0,1,0));
    end

    // LDUR with two data wait cycles: retires in cycle 7
    dmem_ready = 1'b0;
    run_cycle("ld_fetch", 3'd0, f_rdy);
    instruction = I_LDUR;
    run_cycle("ld_decode", 3'd1, 16'h0);
    run_cycle("ld_exec", 3'd2, cv(0,0,0,0,0,0,0,1,4'b0010,0,0,0,0));
    run_cycle("ld_mem_w1", 3'd3, mem_ld);
    run_cycle("ld_mem_w2", 3'd3, mem_ld);
    dmem_ready = 1'b1;
    run_cycle("ld_mem_rdy", 3'd3, mem_ld);
    run_cycle("ld_wb", 3'd4, cv(0,0,0,0,1,1,0,0,4'b0000,1,0,1,0));

    // STUR preceded by one instruction-memory wait cycle
    imem_ready = 1'b0;
    run_cycle("st_fetch_wait", 3'd0, f_wait);
    imem_ready = 1'b1;
    run_cycle("st_fetch", 3'd0, f_rdy);
    instruction = I_STUR;
    run_cycle("st_decode", 3'd1, 16'h0);
    run_cycle("st_exec", 3'd2, cv(0,0,0,0,0,0,0,1,4'b0010,0,0,0,0));
    run_cycle("st_mem", 3'd3, cv(0,0,1,1,0,0,1,1,4'b0010,1,0,1,0));

    // CBZ taken, CBZ not taken, B with zero low
    run_cycle("cbz1_fetch", 3'd0, f_rdy);
    instruction = I_CBZ; zero = 1'b1;
    run_cycle("cbz1_decode", 3'd1, 16'h0);
    run_cycle("cbz1_branch", 3'd5, br_cbz1);
    zero = 1'b0;
    run_cycle("cbz0_fetch", 3'd0, f_rdy);
    run_cycle("cbz0_decode", 3'd1, 16'h0);
    run_cycle("cbz0_branch", 3'd5, br_cbz0);
    run_cycle("b_fetch", 3'd0, f_rdy);
    instruction = I_B;
    run_cycle("b_decode", 3'd1, 16'h0);
    run_cycle("b_branch", 3'd5, br_b);

    // Illegal instruction halts; only reset recovers
    run_cycle("ill_fetch", 3'd0, f_rdy);
    instruction = 32'h0;
    run_cycle("ill_decode", 3'd1, 16'h0);
    for (int k = 0; k < 10; k++) run_cycle("halt", 3'd7, hlt);
    #2;
    reset_n = 1'b0;
    #1;
    check("halt_async_reset", 3'd0, 16'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_cycle("halt_recover_fetch", 3'd0, f_rdy);

    // Reset asserted during LDUR memory wait: everything drops at once
    dmem_ready = 1'b0;
    instruction = I_LDUR;
    run_cycle("abort_decode", 3'd1, 16'h0);
    run_cycle("abort_exec", 3'd2, cv(0,0,0,0,0,0,0,1,4'b0010,0,0,0,0));
    @(negedge clk);
    check("abort_mem", 3'd3, mem_ld);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_in_reset", 3'd0, 16'h0);
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_reset_edge", 3'd0, 16'h0);
    reset_n = 1'b1;
    run_cycle("abort_refetch", 3'd0, f_rdy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
